// File: rtl/agu_conv_walk_if.sv
// Handshake and beat bus between a job issuer and the convolution address walker.
interface agu_conv_walk_if #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TRIP_W = 8,
  parameter int unsigned LIM_W  = 6
) ();
  logic              start_conv;
  logic [IDX_W-1:0]  conf_idx_cnt;
  logic [TRIP_W-1:0] conf_trip_cnt;
  logic              conf_is_new;
  logic              conf_pad_u;
  logic              conf_pad_l;
  logic [LIM_W-1:0]  conf_lim_r;
  logic [LIM_W-1:0]  conf_lim_d;
  logic              stall;
  logic              busy;
  logic              addr_vld;
  logic [IDX_W-1:0]  idx_addr;
  logic [LIM_W-1:0]  row;
  logic [LIM_W-1:0]  col;
  logic              pad;
  logic              acc_clr;
  logic              done;

  modport master (
    output start_conv, conf_idx_cnt, conf_trip_cnt, conf_is_new, conf_pad_u, conf_pad_l,
           conf_lim_r, conf_lim_d, stall,
    input  busy, addr_vld, idx_addr, row, col, pad, acc_clr, done
  );

  modport slave (
    input  start_conv, conf_idx_cnt, conf_trip_cnt, conf_is_new, conf_pad_u, conf_pad_l,
           conf_lim_r, conf_lim_d, stall,
    output busy, addr_vld, idx_addr, row, col, pad, acc_clr, done
  );
endinterface

// File: rtl/agu_conv_walk.sv
// Convolution address walker: one registered beat per unstalled cycle over the
// idx x trip loop of a job, with window row/column and padding classification.
module agu_conv_walk #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TRIP_W = 8,
  parameter int unsigned LIM_W  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  agu_conv_walk_if.slave bus
);

  localparam int unsigned SW = LIM_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx_cnt;
    logic [TRIP_W-1:0] trip_cnt;
    logic              is_new;
    logic              pad_u;
    logic              pad_l;
    logic [LIM_W-1:0]  lim_r;
    logic [LIM_W-1:0]  lim_d;
  } cfg_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LIM_W-1:0] row;
    logic [LIM_W-1:0] col;
    logic             pad;
    logic             acc_clr;
  } beat_t;

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [TRIP_W-1:0] t_q, t_d;
  beat_t             beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;

  logic last_beat_c;
  logic last_trip_c;
  logic zero_job_c;

  // Beat contents for loop position (i, t); x/y go negative when a pad row/column is in front.
  function automatic beat_t beat_f(input cfg_t c, input logic [IDX_W-1:0] i,
                                   input logic [TRIP_W-1:0] t);
    logic signed [SW-1:0] x;
    logic signed [SW-1:0] y;
    beat_t                b;
    x = $signed(SW'(t >> 1)) - $signed(SW'(c.pad_l));
    y = $signed(SW'(t[0]))   - $signed(SW'(c.pad_u));
    b.idx     = i;
    b.row     = y[LIM_W-1:0];
    b.col     = x[LIM_W-1:0];
    b.pad     = x[SW-1] | y[SW-1] |
                (x > $signed(SW'(c.lim_r))) | (y > $signed(SW'(c.lim_d)));
    b.acc_clr = c.is_new & (t == '0);
    return b;
  endfunction

  assign last_trip_c = (t_q == cfg_q.trip_cnt - TRIP_W'(1));
  assign last_beat_c = last_trip_c && (i_q == cfg_q.idx_cnt - IDX_W'(1));
  assign zero_job_c  = (bus.conf_idx_cnt == '0) || (bus.conf_trip_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_conv) state_d = zero_job_c ? S_FIN : S_RUN;
      S_RUN:   if (!bus.stall && last_beat_c) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, config and output next values; a stalled RUN cycle holds everything.
  always_comb begin
    cfg_d  = cfg_q;
    i_d    = i_q;
    t_d    = t_q;
    beat_d = beat_q;
    busy_d = busy_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        vld_d  = 1'b0;
        if (bus.start_conv) begin
          cfg_d  = '{idx_cnt: bus.conf_idx_cnt, trip_cnt: bus.conf_trip_cnt,
                     is_new: bus.conf_is_new, pad_u: bus.conf_pad_u, pad_l: bus.conf_pad_l,
                     lim_r: bus.conf_lim_r, lim_d: bus.conf_lim_d};
          i_d    = '0;
          t_d    = '0;
          busy_d = 1'b1;
          if (zero_job_c) begin
            done_d = 1'b1;
          end else begin
            vld_d  = 1'b1;
            beat_d = beat_f(cfg_d, '0, '0);
          end
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (last_beat_c) begin
            vld_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            if (last_trip_c) begin
              t_d = '0;
              i_d = i_q + IDX_W'(1);
            end else begin
              t_d = t_q + TRIP_W'(1);
            end
            beat_d = beat_f(cfg_q, i_d, t_d);
          end
        end
      end
      S_FIN: begin
        busy_d = 1'b0;
        vld_d  = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        vld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      i_q    <= '0;
      t_q    <= '0;
      beat_q <= '0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      i_q    <= i_d;
      t_q    <= t_d;
      beat_q <= beat_d;
      busy_q <= busy_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.addr_vld = vld_q;
  assign bus.idx_addr = beat_q.idx;
  assign bus.row      = beat_q.row;
  assign bus.col      = beat_q.col;
  assign bus.pad      = beat_q.pad;
  assign bus.acc_clr  = beat_q.acc_clr;
  assign bus.done     = done_q;

endmodule
